muldiv_sequencer: RTL and testbench

- Multi-cycle controller that replaces the combinational multiply/divide path feeding the HI/LO registers.
- Accepts one MUL/MULTU/DIV/DIVU request and runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations.
- Stalls the CPU (PC/regfile enable) while busy, then pulses a single HI/LO write.
- Sits between the decoder/controller op flags and the HI_LO register.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_signfix.sv | 13 +
 rtl/muldiv_sequencer.sv | 146 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// op encodings, FSM states and small decode helpers.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the decoder/controller and the sequencer.
// master = CPU side (drives the request), slave = sequencer.
interface muldiv_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             done;
    logic             hilo_w;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  stall, done, hilo_w, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output stall, done, hilo_w, hi_out, lo_out, div_by_zero
    );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: abs() when i_neg is the operand sign,
// sign restore when i_neg is the recorded result sign.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? -i_val : i_val;

endmodule

// File: rtl/muldiv_sequencer.sv
// Radix-2 shift-add multiply / restoring divide sequencer driving HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the multiplier is exhausted.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e             r_state;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_res, r_neg_rem, r_dz;
    logic               r_done, r_dz_out;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_a_neg, w_b_neg, w_early_out, w_q_bit;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_diff, w_rem_fix;
    logic [WIDTH:0]     w_rem_sh;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_fix_in, w_prod_fix;

    assign w_a_neg = is_signed_op(r_op) & r_a[WIDTH-1];
    assign w_b_neg = is_signed_op(r_op) & r_b[WIDTH-1];

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.i_val(r_a), .i_neg(w_a_neg), .o_val(w_abs_a));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.i_val(r_b), .i_neg(w_b_neg), .o_val(w_abs_b));

    // Divide keeps {rem, quo} in r_acc and the divisor in r_mplier.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_mplier});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_mplier;
    assign w_div_next = {w_q_bit ? w_diff : w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_q_bit};
    assign w_mul_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_fix_in = is_div(r_op) ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;

    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.i_val(w_fix_in), .i_neg(r_neg_res), .o_val(w_prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem_fix)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early_out = !is_div(r_op) && (r_mplier == '0);
`else
    assign w_early_out = 1'b0;
`endif

    assign bus.stall       = ((r_state == IDLE) && bus.start) || (r_state inside {PREP, CALC, FIX});
    assign bus.done        = r_done;
    assign bus.hilo_w      = r_done;
    assign bus.div_by_zero = r_dz_out;
    assign bus.hi_out      = r_hi;
    assign bus.lo_out      = r_lo;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value of every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_op      <= OP_MUL;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
            r_dz_out  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_state <= PREP;
                    end
                end
                PREP: begin
                    r_mplier  <= w_abs_b;
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_dz      <= is_div(r_op) && (r_b == '0);
                    r_cnt     <= CW'(WIDTH - 1);
                    if (is_div(r_op)) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mcand <= '0;
                    end else begin
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
                    end
                    r_state <= CALC;
                end
                CALC: begin
                    if (w_early_out) begin
                        r_state <= FIX;
                    end else begin
                        if (is_div(r_op)) begin
                            r_acc <= w_div_next;
                        end else begin
                            r_acc    <= w_mul_next;
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                        end
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) r_state <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero bypasses the sign fix: HI keeps the raw dividend.
                    if (r_dz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (is_div(r_op)) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done   <= 1'b1;
                    r_dz_out <= r_dz;
                    r_state  <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, latency, start
// masking, mid-operation reset and randomized back-to-back operations.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        bit           stall_ok;
        bit           pulse_ok;
        bit           hold_ok;
    } obs_t;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    // Reference model: plain arithmetic on 64-bit values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dz, output int lat);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        logic [W-1:0] mag;
        int           top;
        sa  = $signed(a);
        sb  = $signed(b);
        dz  = 1'b0;
        lat = W + 2;
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == '0) begin dz = 1'b1; hi = a; lo = '1; end
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            end
            default: begin
                if (b == '0) begin dz = 1'b1; hi = a; lo = '1; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            mag = (op == 2'b00 && b[W-1]) ? -b : b;
            top = -1;
            for (int i = 0; i < W; i++) if (mag[i]) top = i;
            lat = (top < 0) ? 3 : 4 + top;
            if (lat > W + 2) lat = W + 2;
        end
`else
        mag = '0;
        top = 0;
        if (mag != '0 || top != 0) lat = 0;
`endif
    endfunction

    // Issues one request at posedge+1 and returns at posedge+1 with the DUT back in IDLE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, output obs_t o);
        o.stall_ok = 1'b1;
        o.pulse_ok = 1'b1;
        o.hold_ok  = 1'b1;
        o.lat      = 0;
        bus.start = 1'b1;
        bus.op    = op_e'(op);
        bus.a     = a;
        bus.b     = b;
        #1;
        if (bus.stall !== 1'b1) o.stall_ok = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && o.lat < 100) begin
            if (bus.stall !== 1'b1 || bus.hilo_w !== 1'b0) o.stall_ok = 1'b0;
            if (noise && o.lat >= 3 && o.lat <= 12) begin
                bus.start = 1'b1;
                bus.op    = op_e'($urandom_range(3));
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            o.lat++;
        end
        bus.start = 1'b0;
        o.hi = bus.hi_out;
        o.lo = bus.lo_out;
        o.dz = bus.div_by_zero;
        if (bus.hilo_w !== 1'b1 || bus.stall !== 1'b0) o.pulse_ok = 1'b0;
        @(posedge clk); #1;
        if (bus.done !== 1'b0 || bus.hilo_w !== 1'b0 || bus.div_by_zero !== 1'b0) o.pulse_ok = 1'b0;
        if (bus.hi_out !== o.hi || bus.lo_out !== o.lo) o.hold_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.stall, bus.done, bus.hilo_w, bus.div_by_zero} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.stall, bus.done, bus.hilo_w, bus.div_by_zero});
        end
        checks++;
        if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
            failures++;
            $display("FAIL reset_hilo got=%h_%h exp=0", bus.hi_out, bus.lo_out);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        vec_t         dir [9];
        obs_t         o;
        logic [W-1:0] mhi, mlo;
        logic         mdz;
        int           mlat;
        dir[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        dir[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
        dir[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        dir[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        dir[4] = '{2'b11, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        dir[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        dir[6] = '{2'b01, 32'd5,         32'd3,         32'd0,         32'd15,        1'b0};
        dir[7] = '{2'b10, 32'h8000_0000, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
        dir[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        for (int i = 0; i < 9; i++) begin
            model(dir[i].op, dir[i].a, dir[i].b, mhi, mlo, mdz, mlat);
            run_op(dir[i].op, dir[i].a, dir[i].b, 1'b0, o);
            checks++;
            if ({o.hi, o.lo} !== {dir[i].hi, dir[i].lo}) begin
                failures++;
                $display("FAIL dir%0d_hilo got=%h_%h exp=%h_%h", i, o.hi, o.lo, dir[i].hi, dir[i].lo);
            end
            checks++;
            if (o.dz !== dir[i].dz) begin
                failures++;
                $display("FAIL dir%0d_dz got=%b exp=%b", i, o.dz, dir[i].dz);
            end
            checks++;
            if (o.lat != mlat) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", i, o.lat, mlat);
            end
            checks++;
            if ({o.stall_ok, o.pulse_ok, o.hold_ok} !== 3'b111) begin
                failures++;
                $display("FAIL dir%0d_protocol stall/pulse/hold got=%b exp=111", i,
                         {o.stall_ok, o.pulse_ok, o.hold_ok});
            end
        end
    endtask

    task automatic test_latency;
        obs_t o;
        int   exp_lat;
`ifdef MULDIV_EARLY_OUT_EN
        exp_lat = 5;
`else
        exp_lat = 34;
`endif
        run_op(2'b01, 32'd5, 32'd3, 1'b0, o);
        checks++;
        if (o.lat != exp_lat || o.lo !== 32'd15 || o.hi !== 32'd0) begin
            failures++;
            $display("FAIL latency_multu5x3 got lat=%0d hi=%h lo=%h exp lat=%0d hi=0 lo=f", o.lat, o.hi, o.lo, exp_lat);
        end
        run_op(2'b11, 32'd1000, 32'd1, 1'b0, o);
        checks++;
        if (o.lat != 34 || o.lo !== 32'd1000) begin
            failures++;
            $display("FAIL latency_divu got lat=%0d lo=%h exp lat=34 lo=3e8", o.lat, o.lo);
        end
    endtask

    task automatic test_start_ignored;
        obs_t o;
        run_op(2'b11, 32'd1000, 32'd7, 1'b1, o);
        checks++;
        if ({o.hi, o.lo} !== {32'd6, 32'd142}) begin
            failures++;
            $display("FAIL start_ignored_hilo got=%h_%h exp=%h_%h", o.hi, o.lo, 32'd6, 32'd142);
        end
        checks++;
        if (o.lat != 34 || o.pulse_ok !== 1'b1) begin
            failures++;
            $display("FAIL start_ignored_timing got lat=%0d pulse_ok=%b exp lat=34 pulse_ok=1", o.lat, o.pulse_ok);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        bit   saw_done = 1'b0;
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'h0000_FFFF;
        bus.b     = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({bus.stall, bus.done, bus.hilo_w, bus.div_by_zero} !== 4'b0 || {bus.hi_out, bus.lo_out} !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got flags=%b hi=%h lo=%h exp all 0",
                     {bus.stall, bus.done, bus.hilo_w, bus.div_by_zero}, bus.hi_out, bus.lo_out);
        end
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.stall !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_mid_no_done got activity=1 exp=0");
        end
        run_op(2'b11, 32'h0000_FFFF, 32'd3, 1'b0, o);
        checks++;
        if ({o.hi, o.lo} !== {32'd0, 32'h0000_5555} || o.lat != 34) begin
            failures++;
            $display("FAIL reset_mid_restart got hi=%h lo=%h lat=%0d exp hi=0 lo=5555 lat=34", o.hi, o.lo, o.lat);
        end
    endtask

    task automatic test_back_to_back;
        obs_t         o;
        logic [1:0]   op;
        logic [W-1:0] a, b, mhi, mlo;
        logic         mdz;
        int           mlat;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(3));
            a  = ($urandom_range(7) == 0) ? 32'h8000_0000 : W'($urandom);
            case ($urandom_range(5))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(255));
                3:       b = 32'hFFFF_FFFF;
                default: b = W'($urandom);
            endcase
            model(op, a, b, mhi, mlo, mdz, mlat);
            run_op(op, a, b, 1'b0, o);
            checks++;
            if ({o.hi, o.lo, o.dz} !== {mhi, mlo, mdz} || o.lat != mlat) begin
                failures++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d exp hi=%h lo=%h dz=%b lat=%0d",
                         i, op, a, b, o.hi, o.lo, o.dz, o.lat, mhi, mlo, mdz, mlat);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_directed();
        test_latency();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
